cordic_pipe_rotator: RTL

//  Fully pipelined CORDIC rotation engine: computes cos/sin of a full-range angle (-pi..+pi).
//  - Parametrised in width, iteration count and guard bits.
//  - Valid/ready stream handshake and a pass-through user tag.
//  - Replaces the fixed 8-bit, first-quadrant-only, handshake-less rotator.
//  - Sits between the phase-accumulator (NCO) stage and downstream mixers.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_stage.sv | 72 +++++++
 rtl/cordic_pipe_rotator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the pipelined CORDIC rotator.
// Angles use binary radians: pi maps to 2^(iw-3) in the internal iw-bit phase word.
package cordic_pkg;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    Q_0   = 2'd0,
    Q_POS = 2'd1,
    Q_NEG = 2'd2
  } quad_e;

  function automatic int atan_lut_val(input int i, input int iw);
    real a;
    a = $atan(1.0 / (2.0 ** i)) / PI * (2.0 ** (iw - 3));
    return $rtoi(a + 0.5);
  endfunction

  // Pre-scaled start vector length so the rotated result lands on unit magnitude.
  function automatic int cordic_gain(input int iter, input int iw);
    real k;
    k = 1.0;
    for (int i = 0; i < iter; i++) begin
      k = k / $sqrt(1.0 + 1.0 / (2.0 ** (2 * i)));
    end
    return $rtoi(k * (2.0 ** (iw - 4)) + 0.5);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation by atan(2^-SHIFT).
// Data moves only when i_en (the pipeline advance) is high.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT     = 0,
  parameter int IW        = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic signed [IW-1:0] i_x,
  input  logic signed [IW-1:0] i_y,
  input  logic signed [IW-1:0] i_z,
  input  quad_e                i_quad,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_valid,
  output logic signed [IW-1:0] o_x,
  output logic signed [IW-1:0] o_y,
  output logic signed [IW-1:0] o_z,
  output quad_e                o_quad,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_valid
);

  localparam logic signed [IW-1:0] ATAN = IW'(atan_lut_val(SHIFT, IW));

  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;
  logic                 w_d;

  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [IW-1:0] r_z;
  quad_e                r_quad;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_valid;

  assign w_xs = i_x >>> SHIFT;
  assign w_ys = i_y >>> SHIFT;
  assign w_d  = ~i_z[IW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
    end
    if (i_en) begin
      if (w_d) begin
        r_x <= i_x - w_ys;
        r_y <= i_y + w_xs;
        r_z <= i_z - ATAN;
      end else begin
        r_x <= i_x + w_ys;
        r_y <= i_y - w_xs;
        r_z <= i_z + ATAN;
      end
      r_quad <= i_quad;
      r_tag  <= i_tag;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;
  assign o_quad  = r_quad;
  assign o_tag   = r_tag;
  assign o_valid = r_valid;

endmodule

// File: rtl/cordic_pipe_rotator.sv
// Fully pipelined CORDIC rotator: full-circle angle in, clipped cos/sin out, valid/ready stream.
// Build option CORDIC_ROUND_EN: round-half-up output reduction; undefined gives truncation.
module cordic_pipe_rotator
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ITER       = 12,
  parameter int GUARD      = 6,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_angle,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_cos,
  output logic [DATA_WIDTH-1:0] out_sin,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int IW = DATA_WIDTH + GUARD + 2;
  localparam logic signed [IW-1:0] HALF_PI   = IW'(1 << (IW - 4));
  localparam logic signed [IW-1:0] X0        = IW'(cordic_gain(ITER, IW));
  localparam logic signed [IW-1:0] ONE_Q     = IW'(1 << (DATA_WIDTH - 2));
  localparam logic signed [IW-1:0] NEG_ONE_Q = -ONE_Q;

  typedef struct packed {
    logic signed [IW-1:0] z;
    quad_e                quad;
    logic [TAG_WIDTH-1:0] tag;
    logic                 valid;
  } fold_t;

  logic                 w_advance;
  logic signed [IW-1:0] w_ang_ext;
  logic signed [IW-1:0] w_fold_z;
  quad_e                w_fold_q;
  fold_t                r_fold;

  logic signed [IW-1:0] w_x     [0:ITER];
  logic signed [IW-1:0] w_y     [0:ITER];
  logic signed [IW-1:0] w_z     [0:ITER];
  quad_e                w_quad  [0:ITER];
  logic [TAG_WIDTH-1:0] w_tag   [0:ITER];
  logic                 w_valid [0:ITER];

  logic signed [IW-1:0] w_c;
  logic signed [IW-1:0] w_s;
  logic signed [IW-1:0] w_c_red;
  logic signed [IW-1:0] w_s_red;
  logic                 w_unused_z;

  // Bubbles are kept in place; the whole pipe stalls only when the output slot is held.
  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  assign w_ang_ext = {{2{in_angle[DATA_WIDTH-1]}}, in_angle, {GUARD{1'b0}}};

  always_comb begin
    w_fold_z = w_ang_ext;
    w_fold_q = Q_0;
    case (in_angle[DATA_WIDTH-1 -: 2])
      2'b01: begin
        w_fold_z = w_ang_ext - HALF_PI;
        w_fold_q = Q_POS;
      end
      2'b10: begin
        w_fold_z = w_ang_ext + HALF_PI;
        w_fold_q = Q_NEG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fold.valid <= 1'b0;
    end else if (w_advance) begin
      r_fold.valid <= in_valid;
    end
    if (w_advance) begin
      r_fold.z    <= w_fold_z;
      r_fold.quad <= w_fold_q;
      r_fold.tag  <= in_tag;
    end
  end

  assign w_x[0]     = X0;
  assign w_y[0]     = '0;
  assign w_z[0]     = r_fold.z;
  assign w_quad[0]  = r_fold.quad;
  assign w_tag[0]   = r_fold.tag;
  assign w_valid[0] = r_fold.valid;

  for (genvar gi = 0; gi < ITER; gi++) begin : g_stage
    cordic_stage #(
      .SHIFT     (gi),
      .IW        (IW),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_advance),
      .i_x     (w_x[gi]),
      .i_y     (w_y[gi]),
      .i_z     (w_z[gi]),
      .i_quad  (w_quad[gi]),
      .i_tag   (w_tag[gi]),
      .i_valid (w_valid[gi]),
      .o_x     (w_x[gi+1]),
      .o_y     (w_y[gi+1]),
      .o_z     (w_z[gi+1]),
      .o_quad  (w_quad[gi+1]),
      .o_tag   (w_tag[gi+1]),
      .o_valid (w_valid[gi+1])
    );
  end

  // Residual angle after the last stage is only a convergence error term.
  assign w_unused_z = ^w_z[ITER];

  always_comb begin
    w_c = w_x[ITER];
    w_s = w_y[ITER];
    case (w_quad[ITER])
      Q_POS: begin
        w_c = -w_y[ITER];
        w_s = w_x[ITER];
      end
      Q_NEG: begin
        w_c = w_y[ITER];
        w_s = -w_x[ITER];
      end
      default: ;
    endcase
  end

`ifdef CORDIC_ROUND_EN
  localparam logic signed [IW-1:0] RND = IW'(1 << (GUARD - 1));
  assign w_c_red = (w_c + RND) >>> GUARD;
  assign w_s_red = (w_s + RND) >>> GUARD;
`else
  assign w_c_red = w_c >>> GUARD;
  assign w_s_red = w_s >>> GUARD;
`endif

  function automatic logic [DATA_WIDTH-1:0] clip_q(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] c;
    c = v;
    if (v > ONE_Q) begin
      c = ONE_Q;
    end else if (v < NEG_ONE_Q) begin
      c = NEG_ONE_Q;
    end
    return DATA_WIDTH'(c);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cos   <= '0;
      out_sin   <= '0;
      out_tag   <= '0;
    end else if (w_advance) begin
      out_valid <= w_valid[ITER];
      out_cos   <= clip_q(w_c_red);
      out_sin   <= clip_q(w_s_red);
      out_tag   <= w_tag[ITER];
    end
  end

endmodule
